// File: rtl/collision_pkg.sv
// Shared codes, screen constants and FSM states for the collision map probe sequencer.
package collision_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int NUM_PROBES = 8;
    localparam int ADDR_W     = 19;

    typedef enum logic [2:0] {
        CODE_EMPTY      = 3'd0,
        CODE_SOLID      = 3'd1,
        CODE_WATER      = 3'd2,
        CODE_LAVA       = 3'd3,
        CODE_GOO        = 3'd4,
        CODE_DOOR_FIRE  = 3'd5,
        CODE_DOOR_WATER = 3'd6,
        CODE_GEM        = 3'd7
    } coll_code_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFinish
    } probe_state_t;

    function automatic logic [1:0] liquid_rank(input coll_code_t code);
        case (code)
            CODE_GOO:   liquid_rank = 2'd3;
            CODE_LAVA:  liquid_rank = 2'd2;
            CODE_WATER: liquid_rank = 2'd1;
            default:    liquid_rank = 2'd0;
        endcase
    endfunction

    // Keeps whichever liquid is more dangerous; non-liquids never replace anything.
    function automatic coll_code_t merge_hazard(input coll_code_t cur, input coll_code_t code);
        merge_hazard = (liquid_rank(code) > liquid_rank(cur)) ? code : cur;
    endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// Maps the latched box origin and a probe index to a map address plus an off-screen flag.
module probe_addr_gen
    import collision_pkg::*;
#(
    parameter int BOX_W = 16,
    parameter int BOX_H = 24
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [2:0]        idx,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    localparam logic signed [11:0] ScreenW = 12'(SCREEN_W);
    localparam logic signed [11:0] ScreenH = 12'(SCREEN_H);

    logic signed [11:0] dx, dy, px, py;

    always_comb begin
        dx = '0;
        dy = '0;
        case (idx)
            3'd0: begin dx = 12'(0);         dy = 12'(BOX_H);     end
            3'd1: begin dx = 12'(BOX_W - 1); dy = 12'(BOX_H);     end
            3'd2: begin dx = 12'(0);         dy = 12'(-1);        end
            3'd3: begin dx = 12'(BOX_W - 1); dy = 12'(-1);        end
            3'd4: begin dx = 12'(-1);        dy = 12'(BOX_H / 2); end
            3'd5: begin dx = 12'(BOX_W);     dy = 12'(BOX_H / 2); end
            3'd6: begin dx = 12'(BOX_W / 2); dy = 12'(BOX_H);     end
            default: begin dx = 12'(BOX_W / 2); dy = 12'(BOX_H - 1); end
        endcase

        px  = $signed({2'b00, x}) + dx;
        py  = $signed({3'b000, y}) + dy;
        oob = px[11] || (px >= ScreenW) || py[11] || (py >= ScreenH);

        // py*640 as (py<<9)+(py<<7)
        addr = oob ? '0 : ({1'b0, py[8:0], 9'b0} + {3'b000, py[8:0], 7'b0} + {9'b0, px[9:0]});
    end

endmodule

// File: rtl/collision_probe.sv
// Issues eight collision-map probes around a character box and publishes movement flags.
module collision_probe
    import collision_pkg::*;
#(
    parameter int BOX_W = 16,
    parameter int BOX_H = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        pos_x,
    input  logic [8:0]        pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_q,
    output logic              busy,
    output logic              done,
    output logic              on_ground,
    output logic              hit_ceiling,
    output logic              block_left,
    output logic              block_right,
    output logic [2:0]        hazard
);

    localparam logic [2:0] LastProbe = 3'(NUM_PROBES - 1);

    probe_state_t      state;
    logic [2:0]        idx;
    logic [9:0]        x_q;
    logic [8:0]        y_q;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_oob;

    // Probe tag pipeline, two stages to line up with the registered ROM read.
    logic       vld_p1, vld_p2, oob_p1, oob_p2;
    logic [2:0] idx_p1, idx_p2;

    logic       ground_q, ceil_q, left_q, right_q;
    logic       ground_d, ceil_d, left_d, right_d;
    coll_code_t hazard_q, hazard_d;
    coll_code_t code;
    logic       solid;

    probe_addr_gen #(
        .BOX_W(BOX_W),
        .BOX_H(BOX_H)
    ) u_addr_gen (
        .x   (x_q),
        .y   (y_q),
        .idx (idx),
        .addr(gen_addr),
        .oob (gen_oob)
    );

    always_comb begin
        code     = oob_p2 ? CODE_SOLID : coll_code_t'(rom_q);
        solid    = (code == CODE_SOLID);
        ground_d = ground_q;
        ceil_d   = ceil_q;
        left_d   = left_q;
        right_d  = right_q;
        hazard_d = hazard_q;
        if (vld_p2) begin
            case (idx_p2)
                3'd0, 3'd1, 3'd6: ground_d = ground_q | solid;
                3'd2, 3'd3:       ceil_d   = ceil_q | solid;
                3'd4:             left_d   = left_q | solid;
                3'd5:             right_d  = right_q | solid;
                default:          ;
            endcase
            if (idx_p2 == 3'd6 || idx_p2 == 3'd7) begin
                hazard_d = merge_hazard(hazard_q, code);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            idx         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rom_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            oob_p1      <= 1'b0;
            oob_p2      <= 1'b0;
            idx_p1      <= '0;
            idx_p2      <= '0;
            ground_q    <= 1'b0;
            ceil_q      <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            hazard_q    <= CODE_EMPTY;
            on_ground   <= 1'b0;
            hit_ceiling <= 1'b0;
            block_left  <= 1'b0;
            block_right <= 1'b0;
            hazard      <= CODE_EMPTY;
        end else begin
            done     <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= vld_p1;
            oob_p2   <= oob_p1;
            idx_p2   <= idx_p1;
            ground_q <= ground_d;
            ceil_q   <= ceil_d;
            left_q   <= left_d;
            right_q  <= right_d;
            hazard_q <= hazard_d;

            unique case (state)
                StIdle: begin
                    // done still high means the result cycle; starts there are dropped
                    if (start && !done) begin
                        state    <= StIssue;
                        x_q      <= pos_x;
                        y_q      <= pos_y;
                        idx      <= '0;
                        busy     <= 1'b1;
                        ground_q <= 1'b0;
                        ceil_q   <= 1'b0;
                        left_q   <= 1'b0;
                        right_q  <= 1'b0;
                        hazard_q <= CODE_EMPTY;
                    end
                end
                StIssue: begin
                    rom_addr <= gen_addr;
                    vld_p1   <= 1'b1;
                    oob_p1   <= gen_oob;
                    idx_p1   <= idx;
                    idx      <= idx + 3'd1;
                    if (idx == LastProbe) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    state <= StFinish;
                end
                StFinish: begin
                    // Last probe lands on this edge, so publish the next-state shadows.
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    on_ground   <= ground_d;
                    hit_ceiling <= ceil_d;
                    block_left  <= left_d;
                    block_right <= right_d;
                    hazard      <= hazard_d;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_probe.sv
// Directed bench for collision_probe with a behavioural 1-cycle collision map ROM.
module tb_collision_probe;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [18:0] rom_addr;
    logic [2:0]  rom_q;
    logic        busy;
    logic        done;
    logic        on_ground;
    logic        hit_ceiling;
    logic        block_left;
    logic        block_right;
    logic [2:0]  hazard;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;

    logic [18:0] addr_log [8];
    int          lat;
    bit          busy_bad;

    collision_probe dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .busy       (busy),
        .done       (done),
        .on_ground  (on_ground),
        .hit_ceiling(hit_ceiling),
        .block_left (block_left),
        .block_right(block_right),
        .hazard     (hazard)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] map_code(input logic [18:0] a);
        int x, y;
        y = int'(a) / 640;
        x = int'(a) % 640;
        case (mode)
            0: map_code = (y == 124) ? 3'd1 : 3'd0;
            1: map_code = (x >= 100 && x <= 115 && y >= 100 && y <= 123) ? 3'd0 : 3'd1;
            3: map_code = (a == 19'd79468) ? 3'd3 : (a == 19'd78828) ? 3'd4 : 3'd0;
            4: map_code = (a == 19'd78828) ? 3'd2 : (a == 19'd79460) ? 3'd5 :
                          (a == 19'd71779) ? 3'd7 : 3'd0;
            default: map_code = 3'd0;
        endcase
    endfunction

    always @(posedge clock) rom_q <= map_code(rom_addr);

    // Pulses start, then logs the 8 addresses and the latency to done (in cycles after E0).
    task automatic run_probe(input logic [9:0] x, input logic [8:0] y);
        @(negedge clock);
        pos_x = x;
        pos_y = y;
        start = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        lat      = -1;
        busy_bad = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clock);
            if (k <= 8) addr_log[k-1] = rom_addr;
            if (done) begin
                lat = k;
                if (busy !== 1'b0) busy_bad = 1'b1;
            end else if (busy !== 1'b1) begin
                busy_bad = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        pos_x = 10'd0;
        pos_y = 9'd0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (rom_addr !== 19'd0) begin
            n_fail++; $display("FAIL reset_rom_addr: got %0d, want 0", rom_addr);
        end
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_done: got %b, want 00", {busy, done});
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b0000 || hazard !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b/%0d, want 0000/0",
                     {on_ground, hit_ceiling, block_left, block_right}, hazard);
        end
        reset = 1'b0;
    endtask

    task automatic test_flat_floor;
        logic [18:0] exp_addr [8];
        exp_addr = '{19'd79460, 19'd79475, 19'd63460, 19'd63475,
                     19'd71779, 19'd71796, 19'd79468, 19'd78828};
        mode = 0;
        run_probe(10'd100, 9'd100);
        n_checks++;
        if (lat !== 10) begin
            n_fail++; $display("FAIL flat_latency: got %0d, want 10", lat);
        end
        n_checks++;
        if (busy_bad !== 1'b0) begin
            n_fail++; $display("FAIL flat_busy: busy wrong during sequence, want 1 then 0 at done");
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (addr_log[i] !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL flat_addr[%0d]: got %0d, want %0d", i, addr_log[i], exp_addr[i]);
            end
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b1000 || hazard !== 3'd0) begin
            n_fail++;
            $display("FAIL flat_flags: got %b/%0d, want 1000/0",
                     {on_ground, hit_ceiling, block_left, block_right}, hazard);
        end
    endtask

    task automatic test_enclosed;
        mode = 1;
        run_probe(10'd100, 9'd100);
        n_checks++;
        if (lat !== 10) begin
            n_fail++; $display("FAIL enclosed_latency: got %0d, want 10", lat);
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b1111 || hazard !== 3'd0) begin
            n_fail++;
            $display("FAIL enclosed_flags: got %b/%0d, want 1111/0",
                     {on_ground, hit_ceiling, block_left, block_right}, hazard);
        end
    endtask

    task automatic test_edges;
        logic [18:0] exp_tl [8];
        logic [18:0] exp_br [8];
        exp_tl = '{19'd15360, 19'd15375, 19'd0, 19'd0, 19'd0, 19'd7696, 19'd15368, 19'd14728};
        exp_br = '{19'd0, 19'd0, 19'd291824, 19'd291839, 19'd300143, 19'd0, 19'd0, 19'd307192};
        mode = 2;
        run_probe(10'd0, 9'd0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (addr_log[i] !== exp_tl[i]) begin
                n_fail++;
                $display("FAIL edge_tl_addr[%0d]: got %0d, want %0d", i, addr_log[i], exp_tl[i]);
            end
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b0110 || hazard !== 3'd0) begin
            n_fail++;
            $display("FAIL edge_tl_flags: got %b/%0d, want 0110/0",
                     {on_ground, hit_ceiling, block_left, block_right}, hazard);
        end
        run_probe(10'd624, 9'd456);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (addr_log[i] !== exp_br[i]) begin
                n_fail++;
                $display("FAIL edge_br_addr[%0d]: got %0d, want %0d", i, addr_log[i], exp_br[i]);
            end
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b1001 || hazard !== 3'd0) begin
            n_fail++;
            $display("FAIL edge_br_flags: got %b/%0d, want 1001/0",
                     {on_ground, hit_ceiling, block_left, block_right}, hazard);
        end
    endtask

    task automatic test_hazard;
        mode = 3;
        run_probe(10'd100, 9'd100);
        n_checks++;
        if (hazard !== 3'd4) begin
            n_fail++; $display("FAIL hazard_goo_over_lava: got %0d, want 4", hazard);
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b0000) begin
            n_fail++;
            $display("FAIL hazard_goo_flags: got %b, want 0000",
                     {on_ground, hit_ceiling, block_left, block_right});
        end
        // Water at probe 7, fire door under a foot, gem at the left probe.
        mode = 4;
        run_probe(10'd100, 9'd100);
        n_checks++;
        if (hazard !== 3'd2) begin
            n_fail++; $display("FAIL hazard_water: got %0d, want 2", hazard);
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b0000) begin
            n_fail++;
            $display("FAIL hazard_water_flags: got %b, want 0000",
                     {on_ground, hit_ceiling, block_left, block_right});
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        int first_done;
        bit idle_bad;
        mode       = 0;
        dones      = 0;
        first_done = -1;
        idle_bad   = 1'b0;
        @(negedge clock);
        pos_x = 10'd100;
        pos_y = 9'd100;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                if (first_done < 0) first_done = k;
            end
            if (k >= 11 && busy !== 1'b0) idle_bad = 1'b1;
            pos_x = 10'd0;
            pos_y = 9'd0;
            start = (k == 3 || k == 10);
        end
        start = 1'b0;
        n_checks++;
        if (dones !== 1 || first_done !== 10) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d done(s) first at %0d, want 1 at 10",
                     dones, first_done);
        end
        n_checks++;
        if (idle_bad !== 1'b0) begin
            n_fail++; $display("FAIL ignore_busy: busy rose after done, want it to stay 0");
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b1000) begin
            n_fail++;
            $display("FAIL ignore_flags: got %b, want 1000",
                     {on_ground, hit_ceiling, block_left, block_right});
        end
    endtask

    task automatic test_back_to_back;
        int lat2;
        mode = 0;
        run_probe(10'd100, 9'd100);
        n_checks++;
        if (lat !== 10 || on_ground !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got lat %0d ground %b, want 10 1", lat, on_ground);
        end
        @(negedge clock);
        pos_x = 10'd0;
        pos_y = 9'd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || {on_ground, hit_ceiling, block_left, block_right} !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_accept_hold: got busy %b flags %b, want 1 1000",
                     busy, {on_ground, hit_ceiling, block_left, block_right});
        end
        lat2 = -1;
        for (int k = 1; k <= 20 && lat2 < 0; k++) begin
            @(negedge clock);
            if (done) lat2 = k;
        end
        n_checks++;
        if (lat2 !== 10) begin
            n_fail++; $display("FAIL b2b_latency: got %0d, want 10", lat2);
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b0110) begin
            n_fail++;
            $display("FAIL b2b_flags: got %b, want 0110",
                     {on_ground, hit_ceiling, block_left, block_right});
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        mode = 1;
        @(negedge clock);
        pos_x = 10'd100;
        pos_y = 9'd100;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy %b done %b addr %0d, want 0 0 0",
                     busy, done, rom_addr);
        end
        n_checks++;
        if ({on_ground, hit_ceiling, block_left, block_right} !== 4'b0000 || hazard !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_flags: got %b/%0d, want 0000/0",
                     {on_ground, hit_ceiling, block_left, block_right}, hazard);
        end
        reset = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clock);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL midreset_no_done: got %0d done(s), want 0", dones);
        end
        run_probe(10'd100, 9'd100);
        n_checks++;
        if (lat !== 10 || {on_ground, hit_ceiling, block_left, block_right} !== 4'b1111) begin
            n_fail++;
            $display("FAIL midreset_restart: got lat %0d flags %b, want 10 1111",
                     lat, {on_ground, hit_ceiling, block_left, block_right});
        end
    endtask

    initial begin
        test_reset();
        test_flat_floor();
        test_enclosed();
        test_edges();
        test_hazard();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
